idma_desc64_mc_apb_frontend: RTL



---
 rtl/idma_desc64_mc_apb_frontend.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/idma_desc64_mc_apb_frontend.sv
// Multi-channel APB front end for the desc64 descriptor path.
// Each channel has a LO staging register and a HI commit register. A HI write
// pushes the 64-bit descriptor address into that channel's FIFO. A HI write to
// a full FIFO is held with APB wait states, and an optional timeout can end it
// with an error.
module idma_desc64_mc_apb_frontend #(
    parameter int unsigned NumChannels  = 2,
    parameter int unsigned FifoDepth    = 4,
    parameter int unsigned StallTimeout = 0,
    parameter int unsigned AddrWidth    = 12
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             apb_psel_i,
    input  logic                             apb_penable_i,
    input  logic                             apb_pwrite_i,
    input  logic [AddrWidth-1:0]             apb_paddr_i,
    input  logic [31:0]                      apb_pwdata_i,
    input  logic [3:0]                       apb_pstrb_i,
    output logic                             apb_pready_o,
    output logic [31:0]                      apb_prdata_o,
    output logic                             apb_pslverr_o,
    output logic [NumChannels-1:0][63:0]     desc_addr_o,
    output logic [NumChannels-1:0]           desc_valid_o,
    input  logic [NumChannels-1:0]           desc_ready_i,
    input  logic [NumChannels-1:0]           busy_i
);

    localparam int unsigned CntW = (StallTimeout > 0) ? $clog2(StallTimeout + 1) : 1;
    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned ChW  = AddrWidth - 5;

    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t CntLimit = cnt_t'(StallTimeout);

    // Advance a FIFO pointer, wrapping modulo FifoDepth
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    logic                 access;
    logic [ChW-1:0]       ch_addr;
    logic [4:0]           offset;
    logic [NumChannels-1:0] ch_sel;
    logic                 ch_ok;
    logic                 is_lo, is_hi, is_st;
    logic                 acc_err;

    logic                 push_req, lo_wr;
    logic [NumChannels-1:0] push_vec, lo_we, pop;
    logic [NumChannels-1:0] fifo_full, fifo_empty;

    logic [NumChannels-1:0][31:0] lo_w, hi_w;
    logic [NumChannels-1:0][7:0]  level_w;

    logic                 sel_full, sel_empty, sel_ready, sel_busy;
    logic [31:0]          sel_lo, sel_hi;
    logic [7:0]           sel_level;
    logic [31:0]          sel_status;

    cnt_t                 wait_cnt_q, wait_cnt_d;

    // Address decode; output gating by rst_ni keeps the bus quiet during reset
    assign access  = apb_psel_i & apb_penable_i & rst_ni;
    assign ch_addr = apb_paddr_i[AddrWidth-1:5];
    assign offset  = apb_paddr_i[4:0];
    assign is_lo   = (offset == 5'h00);
    assign is_hi   = (offset == 5'h04);
    assign is_st   = (offset == 5'h08);
    assign ch_ok   = |ch_sel;
    assign acc_err = ~ch_ok
                   | (apb_paddr_i[1:0] != 2'b00)
                   | ~(is_lo | is_hi | is_st)
                   | (apb_pwrite_i & is_st)
                   | (apb_pwrite_i & (is_lo | is_hi) & (apb_pstrb_i != 4'hF));

    // One-hot channel select and the selected channel's state
    always_comb begin
        ch_sel    = '0;
        sel_full  = 1'b0;
        sel_empty = 1'b0;
        sel_ready = 1'b0;
        sel_busy  = 1'b0;
        sel_lo    = '0;
        sel_hi    = '0;
        sel_level = '0;
        for (int c = 0; c < NumChannels; c++) begin
            ch_sel[c] = (ch_addr == ChW'(c));
            if (ch_sel[c]) begin
                sel_full  = fifo_full[c];
                sel_empty = fifo_empty[c];
                sel_ready = desc_ready_i[c];
                sel_busy  = busy_i[c];
                sel_lo    = lo_w[c];
                sel_hi    = hi_w[c];
                sel_level = level_w[c];
            end
        end
    end

    assign sel_status = {15'b0, sel_busy, 6'b0, sel_empty, sel_full, sel_level};

    // APB access handling: completion, error, read mux, commit and stall counting
    always_comb begin
        apb_pready_o  = 1'b0;
        apb_pslverr_o = 1'b0;
        apb_prdata_o  = '0;
        push_req      = 1'b0;
        lo_wr         = 1'b0;
        wait_cnt_d    = '0;
        if (access) begin
            if (acc_err) begin
                apb_pready_o  = 1'b1;
                apb_pslverr_o = 1'b1;
            end else if (!apb_pwrite_i) begin
                apb_pready_o = 1'b1;
                apb_prdata_o = is_lo ? sel_lo : (is_hi ? sel_hi : sel_status);
            end else if (is_lo) begin
                apb_pready_o = 1'b1;
                lo_wr        = 1'b1;
            end else if (!sel_full || sel_ready) begin
                // A same-cycle pop frees the slot the push needs
                apb_pready_o = 1'b1;
                push_req     = 1'b1;
            end else if ((StallTimeout != 0) && (wait_cnt_q == CntLimit)) begin
                apb_pready_o  = 1'b1;
                apb_pslverr_o = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    assign push_vec = {NumChannels{push_req}} & ch_sel;
    assign lo_we    = {NumChannels{lo_wr}} & ch_sel;

    // Wait-state counter; anything other than a continuing stall clears it
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    for (genvar gi = 0; gi < NumChannels; gi++) begin : g_ch
        logic [63:0]     mem_q [FifoDepth];
        logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
        logic [7:0]      level_q;
        logic [31:0]     lo_q, hi_q;

        assign fifo_empty[gi] = (level_q == 8'd0);
        assign fifo_full[gi]  = (level_q == 8'(FifoDepth));
        assign pop[gi]        = ~fifo_empty[gi] & desc_ready_i[gi];

        assign desc_valid_o[gi] = ~fifo_empty[gi];
        assign desc_addr_o[gi]  = fifo_empty[gi] ? 64'd0 : mem_q[rd_ptr_q];

        assign lo_w[gi]    = lo_q;
        assign hi_w[gi]    = hi_q;
        assign level_w[gi] = level_q;

        // FIFO storage; contents are only visible while the level is non-zero
        always_ff @(posedge clk_i) begin
            if (push_vec[gi]) begin
                mem_q[wr_ptr_q] <= {apb_pwdata_i, lo_q};
            end
        end

        // FIFO pointers and fill level
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push_vec[gi]) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop[gi])      rd_ptr_q <= ptr_inc(rd_ptr_q);
                case ({push_vec[gi], pop[gi]})
                    2'b10:   level_q <= level_q + 8'd1;
                    2'b01:   level_q <= level_q - 8'd1;
                    default: level_q <= level_q;
                endcase
            end
        end

        // LO staging and last-committed HI word
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                lo_q <= '0;
                hi_q <= '0;
            end else begin
                if (lo_we[gi])    lo_q <= apb_pwdata_i;
                if (push_vec[gi]) hi_q <= apb_pwdata_i;
            end
        end
    end

endmodule
